// File: rtl/uart_wb_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone bridge master.
// Command/response byte values as seen on the serial link.
package uart_wb_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_BUS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/uart_wb_resp_ser.sv
// Response serializer: loaded with a byte count and a left-justified word,
// it presents bytes MSB first on a valid/ready interface.
module uart_wb_resp_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [2:0]  i_count,
    input  logic [31:0] i_word,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [31:0] word_q, word_d;
    logic [2:0]  rem_q, rem_d;
    logic        valid_q, valid_d;
    logic        fire;

    assign fire       = valid_q && i_tx_ready;
    assign o_done     = fire && (rem_q == 3'd1);
    assign o_tx_data  = word_q[31:24];
    assign o_tx_valid = valid_q;

    always_comb begin
        word_d  = word_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        if (i_load) begin
            word_d  = i_word;
            rem_d   = i_count;
            valid_d = (i_count != 3'd0);
        end else if (fire) begin
            // Shift the next byte into the output slot so bytes flow back-to-back.
            word_d = {word_q[23:0], 8'h00};
            rem_d  = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone bridge master: parses W/R frames from the rx byte stream,
// runs one 32-bit Wishbone cycle with an ack timeout, and streams back a response.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [3:0]  SEL_DEFAULT = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        o_busy,
    output logic        o_drop
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] tmo_q, tmo_d;
    logic        drop_q, drop_d;

    logic        ser_load;
    logic [2:0]  ser_count;
    logic [31:0] ser_word;
    logic        ser_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        tmo_d     = tmo_q;
        drop_d    = 1'b0;
        ser_load  = 1'b0;
        ser_count = 3'd1;
        ser_word  = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
                        is_wr_d = (i_rx_data == CMD_WR);
                        cnt_d   = 2'd0;
                        state_d = ST_ADDR;
                    end else begin
                        ser_load = 1'b1;
                        ser_word = {RSP_BAD, 24'h0};
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (i_rx_valid) begin
                    adr_d = {adr_q[23:0], i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            // Bus cycle starts on the same edge that takes the last byte.
                            state_d = ST_BUS;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                            sel_d   = 4'hF;
                            tmo_d   = '0;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (i_rx_valid) begin
                    wdat_d = {wdat_q[23:0], i_rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        sel_d   = SEL_DEFAULT;
                        tmo_d   = '0;
                    end
                end
            end
            ST_BUS: begin
                drop_d = i_rx_valid;
                if (wbm_ack_i) begin
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = 4'h0;
                    ser_load = 1'b1;
                    state_d  = ST_RESP;
                    if (we_q) begin
                        ser_word = {RSP_OK, 24'h0};
                    end else begin
                        ser_count = 3'd4;
                        ser_word  = wbm_dat_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = 4'h0;
                    ser_load = 1'b1;
                    ser_word = {RSP_ERR, 24'h0};
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RESP: begin
                drop_d = i_rx_valid;
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            tmo_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
        end
    end

    uart_wb_resp_ser u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (ser_load),
        .i_count    (ser_count),
        .i_word     (ser_word),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (ser_done)
    );

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_drop    = drop_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Scoreboard bench for uart_wb_master: random frames, a Wishbone slave model
// with programmable ack latency, and monitors for the bus and tx byte stream.
module tb_uart_wb_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        o_busy, o_drop;

    uart_wb_master #(.TIMEOUT(TMO), .SEL_DEFAULT(4'hF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .o_busy     (o_busy),
        .o_drop     (o_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] dur;
    } bus_t;

    bus_t        exp_bus[$];
    logic [8:0]  exp_tx[$];   // {last, byte}
    int          total = 0;
    int          bad = 0;
    int          slv_lat = 0;
    logic [31:0] slv_rdata = '0;
    int          slv_wait = 0;
    int          ready_mode = 0;  // 0 random, 1 always ready, 2 stalled
    bit          rst_abort = 1'b0;
    int          drop_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: acks on the slv_lat-th cycle of each bus cycle; negative latency never acks.
    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) begin
            if (slv_lat >= 0 && slv_wait == slv_lat) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = slv_rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            slv_wait++;
        end else begin
            wbm_ack_i = 1'b0;
            slv_wait  = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       i_tx_ready = ($urandom_range(0, 3) != 0);
            1:       i_tx_ready = 1'b1;
            default: i_tx_ready = 1'b0;
        endcase
    end

    // tx monitor
    logic       tx_prev_v = 1'b0, tx_prev_r = 1'b0;
    logic [7:0] tx_prev_d = '0;
    int         tx_expect_next = -1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_expect_next >= 0) chk("tx_valid_after_hs", 32'(o_tx_valid), 32'(tx_expect_next));
            tx_expect_next = -1;
            if (tx_prev_v && !tx_prev_r)
                chk("tx_hold", 32'({o_tx_valid, o_tx_data}), 32'({1'b1, tx_prev_d}));
            if (o_tx_valid && i_tx_ready) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %h expected no byte at %0t", o_tx_data, $time);
                end else begin
                    logic [8:0] e;
                    e = exp_tx.pop_front();
                    chk("tx_byte", 32'(o_tx_data), 32'(e[7:0]));
                    tx_expect_next = e[8] ? 0 : 1;
                end
            end
            tx_prev_v = o_tx_valid;
            tx_prev_r = i_tx_ready;
            tx_prev_d = o_tx_data;
        end else begin
            tx_prev_v      = 1'b0;
            tx_expect_next = -1;
        end
    end

    // Bus monitor
    logic cyc_prev = 1'b0;
    int   bus_dur = 0;
    bus_t cur;
    always @(negedge clk) begin
        if (wbm_cyc_o && !cyc_prev) begin
            bus_dur = 1;
            if (exp_bus.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected: got adr %h expected no cycle at %0t", wbm_adr_o, $time);
                cur = '0;
            end else begin
                cur = exp_bus.pop_front();
                chk("bus_adr", wbm_adr_o, cur.adr);
                chk("bus_we", 32'(wbm_we_o), 32'(cur.we));
                chk("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
                chk("bus_stb", 32'(wbm_stb_o), 32'd1);
                if (cur.we) chk("bus_dat", wbm_dat_o, cur.dat);
            end
        end else if (wbm_cyc_o) begin
            bus_dur++;
            chk("bus_adr_stable", wbm_adr_o, cur.adr);
            chk("bus_we_stable", 32'(wbm_we_o), 32'(cur.we));
        end else if (cyc_prev && !rst_abort) begin
            chk("bus_len", 32'(bus_dur), cur.dur);
            chk("rsp_latency", 32'(o_tx_valid), 32'd1);
            chk("bus_clear", 32'({wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
        end
        cyc_prev = wbm_cyc_o;
    end

    always @(negedge clk) if (o_drop) drop_cnt++;

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [31:0] adr,
                               input logic [31:0] wd, input int lat, input logic [31:0] rd);
        bus_t b;
        slv_lat   = lat;
        slv_rdata = rd;
        if (cmd == 8'h57 || cmd == 8'h52) begin
            b.adr = adr;
            b.we  = (cmd == 8'h57);
            b.dat = wd;
            b.sel = 4'hF;
            b.dur = (lat < 0) ? 32'(TMO) : 32'(lat + 1);
            exp_bus.push_back(b);
            if (lat < 0) exp_tx.push_back({1'b1, 8'h45});
            else if (cmd == 8'h57) exp_tx.push_back({1'b1, 8'h4B});
            else for (int i = 3; i >= 0; i--) exp_tx.push_back({(i == 0), rd[i*8 +: 8]});
            send_byte(cmd);
            for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
            if (cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(wd[i*8 +: 8]);
        end else begin
            exp_tx.push_back({1'b1, 8'h3F});
            send_byte(cmd);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!o_busy && exp_tx.size() == 0) break;
        end
        chk(name, 32'(n < 2000), 32'd1);
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] adr,
                            input logic [31:0] wd, input int lat, input logic [31:0] rd,
                            input string name);
        start_frame(cmd, adr, wd, lat, rd);
        wait_idle(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [7:0]  c;
        logic [31:0] a, w, r;
        int          lat;

        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_txv", 32'(o_tx_valid), 32'd0);
        chk("rst_txd", 32'(o_tx_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);
        rst_n = 1'b1;

        ready_mode = 0;
        do_frame(8'h57, 32'h3000_0004, 32'hDEAD_BEEF, 3, 32'h0, "done_write");
        ready_mode = 1;
        do_frame(8'h52, 32'h3800_0010, 32'h0, 0, 32'h1234_5678, "done_read");
        ready_mode = 0;
        do_frame(8'h52, 32'h3000_0020, 32'h0, -1, 32'h0, "done_timeout");

        // Backpressure with a byte injected while the response is pending
        ready_mode = 2;
        start_frame(8'h52, 32'h3800_0010, 32'h0, 1, 32'h1234_5678);
        for (n = 0; n < 200 && !o_tx_valid; n++) @(negedge clk);
        chk("bp_valid", 32'(o_tx_valid), 32'd1);
        d0 = drop_cnt;
        send_byte(8'hAA);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", 32'(o_tx_data), 32'h12);
        end
        chk("drop_once", 32'(drop_cnt - d0), 32'd1);
        ready_mode = 1;
        wait_idle("done_bp");

        ready_mode = 0;
        do_frame(8'h41, 32'h0, 32'h0, 0, 32'h0, "done_bad");
        do_frame(8'h57, 32'h3000_0008, 32'h0BAD_F00D, 1, 32'h0, "done_after_bad");

        // Reset in the middle of a bus cycle
        start_frame(8'h52, 32'h3000_0040, 32'h0, -1, 32'h0);
        for (n = 0; n < 50 && !wbm_cyc_o; n++) @(negedge clk);
        chk("rst_mid_cyc_seen", 32'(wbm_cyc_o), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_abort = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_mid_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_txv", 32'(o_tx_valid), 32'd0);
        exp_tx.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rst_abort = 1'b0;
        do_frame(8'h52, 32'h3800_0000, 32'h0, 2, 32'hA5A5_5A5A, "done_after_rst");

        for (int k = 0; k < 24; k++) begin
            n = $urandom_range(0, 9);
            if (n < 4) c = 8'h57;
            else if (n < 8) c = 8'h52;
            else begin
                c = 8'($urandom);
                while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
            end
            a   = $urandom;
            w   = $urandom;
            r   = $urandom;
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            do_frame(c, a, w, lat, r, "done_rand");
        end

        repeat (5) @(negedge clk);
        chk("drop_total", 32'(drop_cnt), 32'd1);
        chk("bus_q_empty", 32'(exp_bus.size()), 32'd0);
        chk("tx_q_empty", 32'(exp_tx.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
